// File: rtl/fxp_add_arbiter_pkg.sv
// Shared Q8.4 fixed-point definitions for the shared-adder arbiter and its datapath.
package fxp_pkg;

    localparam int FXP_INT_W  = 8;
    localparam int FXP_FRAC_W = 4;
    localparam int FXP_W      = FXP_INT_W + FXP_FRAC_W;

    typedef logic [FXP_W-1:0] fxp_t;

    // Joins an integer part and a fractional part into one Q8.4 word
    function automatic fxp_t fxp_pack(input logic [FXP_INT_W-1:0] int_part,
                                      input logic [FXP_FRAC_W-1:0] frac_part);
        return {int_part, frac_part};
    endfunction

endpackage

// File: rtl/fxp_add_arbiter_if.sv
// Bundle of the requester-side and result-side handshake signals of the shared adder.
// The master side is the client/downstream environment; the slave side is the arbiter.
interface fxp_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a_integer;
    logic [NUM_REQ*4-1:0] req_a_fractional;
    logic [NUM_REQ*8-1:0] req_b_integer;
    logic [NUM_REQ*4-1:0] req_b_fractional;

    logic                 out_valid;
    logic                 out_ready;
    logic [ID_W-1:0]      out_id;
    logic [7:0]           out_integer;
    logic [3:0]           out_fractional;
    logic                 out_carry;

    modport master (
        output req_valid, req_a_integer, req_a_fractional,
               req_b_integer, req_b_fractional, out_ready,
        input  req_ready, out_valid, out_id, out_integer,
               out_fractional, out_carry
    );

    modport slave (
        input  req_valid, req_a_integer, req_a_fractional,
               req_b_integer, req_b_fractional, out_ready,
        output req_ready, out_valid, out_id, out_integer,
               out_fractional, out_carry
    );

endinterface

// File: rtl/fxp_add_q8_4.sv
// Combinational unsigned Q8.4 adder with optional clamp to full scale on overflow.
module fxp_add_q8_4
    import fxp_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  fxp_t a,
    input  fxp_t b,
    output fxp_t sum,
    output logic carry
);

    logic [FXP_W:0] sum_wide;

    // Full-width add; the carry is always reported, the clamp only changes the value
    always_comb begin
        sum_wide = {1'b0, a} + {1'b0, b};
        carry    = sum_wide[FXP_W];
        if (SATURATE && carry) begin
            sum = '1;
        end else begin
            sum = sum_wide[FXP_W-1:0];
        end
    end

endmodule

// File: rtl/fxp_add_arbiter.sv
// Round-robin arbiter sharing one Q8.4 adder among NUM_REQ requesters.
// The result register doubles as the state: out_valid=0 is EMPTY, out_valid=1 is FULL.
module fxp_add_arbiter
    import fxp_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    fxp_add_arbiter_if.slave bus
);

    logic [ID_W-1:0] ptr;
    logic            found;
    int              win_idx;
    logic            can_accept;
    logic            take;
    fxp_t            op_a;
    fxp_t            op_b;
    fxp_t            sum;
    logic            carry;

    // Search from the pointer upward with wrap; the first valid requester wins
    always_comb begin
        int idx;
        found   = 1'b0;
        win_idx = 0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign can_accept = !bus.out_valid || bus.out_ready;
    assign take       = found && can_accept && !rst;

    // Only the winner sees ready, and only when the result register is free to load
    always_comb begin
        bus.req_ready = '0;
        if (take) begin
            bus.req_ready[win_idx] = 1'b1;
        end
    end

    assign op_a = fxp_pack(bus.req_a_integer[win_idx*FXP_INT_W +: FXP_INT_W],
                           bus.req_a_fractional[win_idx*FXP_FRAC_W +: FXP_FRAC_W]);
    assign op_b = fxp_pack(bus.req_b_integer[win_idx*FXP_INT_W +: FXP_INT_W],
                           bus.req_b_fractional[win_idx*FXP_FRAC_W +: FXP_FRAC_W]);

    fxp_add_q8_4 #(
        .SATURATE (SATURATE)
    ) u_add (
        .a     (op_a),
        .b     (op_b),
        .sum   (sum),
        .carry (carry)
    );

    // Result register and pointer: load on transfer, drain on out_ready, hold on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.out_id         <= '0;
            bus.out_integer    <= '0;
            bus.out_fractional <= '0;
            bus.out_carry      <= 1'b0;
            ptr                <= '0;
        end else if (take) begin
            bus.out_valid      <= 1'b1;
            bus.out_id         <= ID_W'(win_idx);
            bus.out_integer    <= sum[FXP_W-1:FXP_FRAC_W];
            bus.out_fractional <= sum[FXP_FRAC_W-1:0];
            bus.out_carry      <= carry;
            ptr                <= ID_W'((win_idx + 1) % NUM_REQ);
        end else if (bus.out_ready) begin
            bus.out_valid      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fxp_add_arbiter.sv
// Directed bench for the shared Q8.4 adder arbiter: a wrapping instance and a saturating one.
module tb_fxp_add_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fxp_add_arbiter_if #(.NUM_REQ(4)) bus ();
    fxp_add_arbiter_if #(.NUM_REQ(4)) bus_s ();

    fxp_add_arbiter #(
        .NUM_REQ  (4),
        .SATURATE (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fxp_add_arbiter #(
        .NUM_REQ  (4),
        .SATURATE (1'b1)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed results for the operand table loaded after the overflow test
    logic [7:0] exp_int   [4] = '{8'h03, 8'h31, 8'h80, 8'h10};
    logic [3:0] exp_frac  [4] = '{4'h3, 4'h0, 4'h0, 4'h4};
    logic       exp_carry [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] ai, input logic [3:0] af,
                           input logic [7:0] bi, input logic [3:0] bf);
        bus.req_a_integer[i*8 +: 8]    = ai;
        bus.req_a_fractional[i*4 +: 4] = af;
        bus.req_b_integer[i*8 +: 8]    = bi;
        bus.req_b_fractional[i*4 +: 4] = bf;
    endtask

    task automatic set_ops_sat(input int i, input logic [7:0] ai, input logic [3:0] af,
                               input logic [7:0] bi, input logic [3:0] bf);
        bus_s.req_a_integer[i*8 +: 8]    = ai;
        bus_s.req_a_fractional[i*4 +: 4] = af;
        bus_s.req_b_integer[i*8 +: 8]    = bi;
        bus_s.req_b_fractional[i*4 +: 4] = bf;
    endtask

    // Linear directed sequence; inputs change 1ns after a rising edge, outputs checked before the next
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.req_valid = '0;        bus_s.req_valid = '0;
        bus.req_a_integer = '0;    bus_s.req_a_integer = '0;
        bus.req_a_fractional = '0; bus_s.req_a_fractional = '0;
        bus.req_b_integer = '0;    bus_s.req_b_integer = '0;
        bus.req_b_fractional = '0; bus_s.req_b_fractional = '0;
        bus.out_ready = 1'b1;      bus_s.out_ready = 1'b1;

        // Reset values
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_id", bus.out_id, 2'd0);
        check("rst_out_integer", bus.out_integer, 8'h00);
        check("rst_out_fractional", bus.out_fractional, 4'h0);
        check("rst_out_carry", bus.out_carry, 1'b0);
        bus.req_valid = 4'hF;
        #1;
        check("rst_req_ready_zero", bus.req_ready, 4'b0000);
        bus.req_valid = 4'h0;
        rst = 1'b0;
        tick();

        // Single request: 5.5 + 2.75 = 8.25 from requester 2
        set_ops(2, 8'h05, 4'h8, 8'h02, 4'hC);
        bus.req_valid = 4'b0100;
        #1;
        check("t1_req_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0000;
        check("t1_out_valid", bus.out_valid, 1'b1);
        check("t1_out_id", bus.out_id, 2'd2);
        check("t1_out_integer", bus.out_integer, 8'h08);
        check("t1_out_fractional", bus.out_fractional, 4'h4);
        check("t1_out_carry", bus.out_carry, 1'b0);
        tick();
        check("t1_drain_valid", bus.out_valid, 1'b0);
        check("t1_drain_hold_int", bus.out_integer, 8'h08);

        // Overflow: FF.F + 00.1 wraps on one instance, clamps on the other
        set_ops(0, 8'hFF, 4'hF, 8'h00, 4'h1);
        set_ops_sat(0, 8'hFF, 4'hF, 8'h00, 4'h1);
        set_ops_sat(1, 8'h10, 4'h8, 8'h20, 4'h8);
        bus.req_valid   = 4'b0001;
        bus_s.req_valid = 4'b0001;
        #1;
        check("t2_req_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid   = 4'b0000;
        bus_s.req_valid = 4'b0010;
        check("t2_wrap_int", bus.out_integer, 8'h00);
        check("t2_wrap_frac", bus.out_fractional, 4'h0);
        check("t2_wrap_carry", bus.out_carry, 1'b1);
        check("t2_sat_int", bus_s.out_integer, 8'hFF);
        check("t2_sat_frac", bus_s.out_fractional, 4'hF);
        check("t2_sat_carry", bus_s.out_carry, 1'b1);
        tick();
        bus_s.req_valid = 4'b0000;
        check("t2_drain_valid", bus.out_valid, 1'b0);
        check("t2_sat_nocarry_id", bus_s.out_id, 2'd1);
        check("t2_sat_nocarry_int", bus_s.out_integer, 8'h31);
        check("t2_sat_nocarry_frac", bus_s.out_fractional, 4'h0);
        check("t2_sat_nocarry_carry", bus_s.out_carry, 1'b0);

        // Operand table for the remaining tests
        set_ops(0, 8'h01, 4'h1, 8'h02, 4'h2);
        set_ops(1, 8'h10, 4'h8, 8'h20, 4'h8);
        set_ops(2, 8'h7F, 4'hF, 8'h00, 4'h1);
        set_ops(3, 8'hC0, 4'h0, 8'h50, 4'h4);

        // Sparse: pointer is 1, only requester 3 valid, then 0 and 3 together
        bus.req_valid = 4'b1000;
        #1;
        check("t6_ready_r3", bus.req_ready, 4'b1000);
        tick();
        check("t6_id_r3", bus.out_id, 2'd3);
        check("t6_int_r3", bus.out_integer, exp_int[3]);
        check("t6_frac_r3", bus.out_fractional, exp_frac[3]);
        check("t6_carry_r3", bus.out_carry, exp_carry[3]);
        bus.req_valid = 4'b1001;
        #1;
        check("t6_ready_r0_first", bus.req_ready, 4'b0001);
        tick();
        check("t6_id_r0", bus.out_id, 2'd0);
        check("t6_int_r0", bus.out_integer, exp_int[0]);
        check("t6_frac_r0", bus.out_fractional, exp_frac[0]);

        // Backpressure: pointer is 1, requesters 1 and 3 pending, output stalled 3 cycles
        bus.req_valid = 4'b1010;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4_stall_ready", bus.req_ready, 4'b0000);
            tick();
            check("t4_stall_valid", bus.out_valid, 1'b1);
            check("t4_stall_id", bus.out_id, 2'd0);
            check("t4_stall_int", bus.out_integer, exp_int[0]);
        end
        bus.out_ready = 1'b1;
        #1;
        check("t4_release_ready", bus.req_ready, 4'b0010);
        tick();
        check("t4_release_valid", bus.out_valid, 1'b1);
        check("t4_release_id", bus.out_id, 2'd1);
        check("t4_release_int", bus.out_integer, exp_int[1]);
        bus.req_valid = 4'b1000;
        #1;
        check("t4_next_ready", bus.req_ready, 4'b1000);
        tick();
        check("t4_next_valid", bus.out_valid, 1'b1);
        check("t4_next_id", bus.out_id, 2'd3);

        // Move the pointer to 2 so a reset that fails to clear it would grant requester 3
        bus.req_valid = 4'b0010;
        tick();
        check("t5_pre_id", bus.out_id, 2'd1);

        // Reset while full with requesters 1 and 3 pending
        bus.req_valid = 4'b1010;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_rst_ready", bus.req_ready, 4'b0000);
        tick();
        check("t5_rst_valid", bus.out_valid, 1'b0);
        check("t5_rst_ready_after", bus.req_ready, 4'b0000);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("t5_first_ready", bus.req_ready, 4'b0010);
        tick();
        check("t5_first_id", bus.out_id, 2'd1);

        // Fresh reset, then all four requesters contend for 8 cycles
        bus.req_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t3_one_hot_ready", bus.req_ready, 32'd1 << (k % 4));
            tick();
            check("t3_valid", bus.out_valid, 1'b1);
            check("t3_id", bus.out_id, k % 4);
            check("t3_int", bus.out_integer, exp_int[k % 4]);
            check("t3_carry", bus.out_carry, exp_carry[k % 4]);
        end
        bus.req_valid = 4'b0000;
        tick();
        check("end_drain_valid", bus.out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
